// File: rtl/mc_control_unit.sv
// Multicycle RV32I(+M) control FSM: sequences fetch/decode/execute/memory/writeback,
// with memory wait states, mul/div handshake and illegal-instruction trapping.
module mc_control_unit #(
   parameter bit MEM_WAIT_EN = 1'b1,
   parameter bit M_EXT       = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       funct7_0,
   input  logic       mem_ready,
   input  logic       md_done,
   output logic [1:0] MemtoReg,
   output logic       MDSel,
   output logic       RegWrite,
   output logic       IorD,
   output logic       MemWrite,
   output logic       MemRead,
   output logic       IRWrite,
   output logic       PCWrite,
   output logic       PCSrc,
   output logic       ALUSrcA,
   output logic [1:0] ALUSrcB,
   output logic [2:0] ALUOp,
   output logic       Branch,
   output logic [2:0] BranchCond,
   output logic       md_start,
   output logic       illegal
);

   typedef enum logic [3:0] {
      S_FETCH           = 4'h0,
      S_DECODE          = 4'h1,
      S_MEMADR          = 4'h2,
      S_MEMREAD         = 4'h3,
      S_MEMREAD_COMP    = 4'h4,
      S_EXECUTE_R       = 4'h5,
      S_COMPLETION      = 4'h6,
      S_BRANCH          = 4'h7,
      S_EXECUTE_J       = 4'h8,
      S_EXECUTE_I       = 4'h9,
      S_COMPLETION_JALR = 4'hA,
      S_EXECUTE_LUI     = 4'hB,
      S_EXECUTE_AUIPC   = 4'hC,
      S_MEMWRITE        = 4'hD,
      S_EXECUTE_MD      = 4'hE,
      S_TRAP            = 4'hF
   } state_t;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   state_t     state_reg, state_next;
   logic [2:0] branch_cond_reg;
   logic       md_sel_reg;
   logic       md_first_reg;
   logic       ready;

   assign ready = MEM_WAIT_EN ? mem_ready : 1'b1;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg       <= S_FETCH;
         branch_cond_reg <= 3'b000;
         md_sel_reg      <= 1'b0;
         md_first_reg    <= 1'b1;
      end else begin
         state_reg <= state_next;
         if (state_reg == S_DECODE)
            branch_cond_reg <= funct3;
         if (state_reg == S_FETCH)
            md_sel_reg <= 1'b0;
         else if (state_reg == S_EXECUTE_MD && md_done)
            md_sel_reg <= 1'b1;
         // md_start fires only on the first EXECUTE_MD cycle of each instruction
         md_first_reg <= !(state_reg == S_EXECUTE_MD && state_next == S_EXECUTE_MD);
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_FETCH:    if (ready) state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_LOAD, OP_STORE: state_next = S_MEMADR;
               OP_R: begin
                  if (funct7_0) state_next = M_EXT ? S_EXECUTE_MD : S_TRAP;
                  else          state_next = S_EXECUTE_R;
               end
               OP_BRANCH: state_next = (funct3 == 3'd2 || funct3 == 3'd3) ? S_TRAP : S_BRANCH;
               OP_IMM, OP_JALR: state_next = S_EXECUTE_I;
               OP_JAL:    state_next = S_EXECUTE_J;
               OP_LUI:    state_next = S_EXECUTE_LUI;
               OP_AUIPC:  state_next = S_EXECUTE_AUIPC;
               default:   state_next = S_TRAP;
            endcase
         end
         S_MEMADR:        state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
         S_MEMREAD:       if (ready) state_next = S_MEMREAD_COMP;
         S_MEMWRITE:      if (ready) state_next = S_FETCH;
         S_EXECUTE_I:     state_next = (opcode == OP_JALR) ? S_COMPLETION_JALR : S_COMPLETION;
         S_EXECUTE_R,
         S_EXECUTE_AUIPC: state_next = S_COMPLETION;
         S_EXECUTE_MD:    if (md_done) state_next = S_COMPLETION;
         default:         state_next = S_FETCH;
      endcase
   end

   always_comb begin
      MemtoReg   = 2'b00;
      MDSel      = 1'b0;
      RegWrite   = 1'b0;
      IorD       = 1'b0;
      MemWrite   = 1'b0;
      MemRead    = 1'b0;
      IRWrite    = 1'b0;
      PCWrite    = 1'b0;
      PCSrc      = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 3'b000;
      Branch     = 1'b0;
      BranchCond = 3'b000;
      md_start   = 1'b0;
      illegal    = 1'b0;
      case (state_reg)
         S_FETCH: begin
            MemRead = 1'b1;
            ALUSrcB = 2'b01;
            IRWrite = ready;
            PCWrite = ready;
         end
         S_DECODE:       ALUSrcB = 2'b10;
         S_MEMADR: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
         end
         S_MEMREAD: begin
            IorD    = 1'b1;
            MemRead = 1'b1;
         end
         S_MEMREAD_COMP: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b01;
         end
         S_MEMWRITE: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
         end
         S_EXECUTE_R: begin
            ALUSrcA = 1'b1;
            ALUOp   = 3'b010;
         end
         S_EXECUTE_I: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
            ALUOp   = 3'b010;
         end
         S_COMPLETION: begin
            RegWrite = 1'b1;
            MDSel    = md_sel_reg;
         end
         S_BRANCH: begin
            Branch     = 1'b1;
            PCSrc      = 1'b1;
            ALUSrcA    = 1'b1;
            ALUOp      = 3'b001;
            BranchCond = branch_cond_reg;
         end
         S_EXECUTE_J, S_COMPLETION_JALR: begin
            PCWrite  = 1'b1;
            PCSrc    = 1'b1;
            MemtoReg = 2'b10;
            RegWrite = 1'b1;
         end
         S_EXECUTE_LUI: begin
            RegWrite = 1'b1;
            MemtoReg = 2'b11;
         end
         S_EXECUTE_AUIPC: ALUSrcB = 2'b10;
         S_EXECUTE_MD:    md_start = md_first_reg;
         S_TRAP:          illegal = 1'b1;
         default: ;
      endcase
      // reset suppresses every side effect immediately, independent of the clock
      if (rst) begin
         IRWrite  = 1'b0;
         PCWrite  = 1'b0;
         RegWrite = 1'b0;
         MemWrite = 1'b0;
         md_start = 1'b0;
         illegal  = 1'b0;
      end
   end

endmodule

// File: tb/tb_mc_control_unit.sv
// Bench for mc_control_unit: directed and random instructions compared per cycle
// against a phase-list model built from the instruction class.
module tb_mc_control_unit;

   typedef struct packed {
      logic [1:0] m2r;
      logic       mdsel;
      logic       regw;
      logic       iord;
      logic       memw;
      logic       memr;
      logic       irw;
      logic       pcw;
      logic       pcsrc;
      logic       asa;
      logic [1:0] asb;
      logic [2:0] aluop;
      logic       br;
      logic [2:0] bc;
      logic       mds;
      logic       ill;
   } ctl_t;

   typedef struct {
      string tag;
      ctl_t  c;
      ctl_t  m;
      int    kind;   // 0 single cycle, 1 memory wait, 2 mul/div wait, 3 fetch
   } phase_t;

   localparam int C_LOAD = 0, C_STORE = 1, C_R = 2, C_MD = 3, C_BR = 4, C_I = 5,
                  C_JALR = 6, C_JAL = 7, C_LUI = 8, C_AUIPC = 9, C_TRAP = 10;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] opcode;
   logic [2:0] funct3;
   logic       funct7_0;
   logic       mem_ready;
   logic       md_done;

   logic [1:0] a_m2r, b_m2r, a_asb, b_asb;
   logic [2:0] a_aluop, b_aluop, a_bc, b_bc;
   logic a_mdsel, a_regw, a_iord, a_memw, a_memr, a_irw, a_pcw, a_pcsrc, a_asa, a_br, a_mds, a_ill;
   logic b_mdsel, b_regw, b_iord, b_memw, b_memr, b_irw, b_pcw, b_pcsrc, b_asa, b_br, b_mds, b_ill;
   ctl_t obs_a, obs_b;

   int     checks = 0;
   int     failures = 0;
   bit     sel;
   bit     wait_en;
   bit     m_ext;
   bit     ready_q[$];
   bit     md_q[$];
   phase_t phases[$];

   always #5 clk = ~clk;

   mc_control_unit #(.MEM_WAIT_EN(1'b1), .M_EXT(1'b1)) dut_a (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
      .mem_ready(mem_ready), .md_done(md_done),
      .MemtoReg(a_m2r), .MDSel(a_mdsel), .RegWrite(a_regw), .IorD(a_iord),
      .MemWrite(a_memw), .MemRead(a_memr), .IRWrite(a_irw), .PCWrite(a_pcw),
      .PCSrc(a_pcsrc), .ALUSrcA(a_asa), .ALUSrcB(a_asb), .ALUOp(a_aluop),
      .Branch(a_br), .BranchCond(a_bc), .md_start(a_mds), .illegal(a_ill)
   );

   mc_control_unit #(.MEM_WAIT_EN(1'b0), .M_EXT(1'b0)) dut_b (
      .clk(clk), .rst(rst), .opcode(opcode), .funct3(funct3), .funct7_0(funct7_0),
      .mem_ready(mem_ready), .md_done(md_done),
      .MemtoReg(b_m2r), .MDSel(b_mdsel), .RegWrite(b_regw), .IorD(b_iord),
      .MemWrite(b_memw), .MemRead(b_memr), .IRWrite(b_irw), .PCWrite(b_pcw),
      .PCSrc(b_pcsrc), .ALUSrcA(b_asa), .ALUSrcB(b_asb), .ALUOp(b_aluop),
      .Branch(b_br), .BranchCond(b_bc), .md_start(b_mds), .illegal(b_ill)
   );

   assign obs_a = {a_m2r, a_mdsel, a_regw, a_iord, a_memw, a_memr, a_irw, a_pcw, a_pcsrc,
                   a_asa, a_asb, a_aluop, a_br, a_bc, a_mds, a_ill};
   assign obs_b = {b_m2r, b_mdsel, b_regw, b_iord, b_memw, b_memr, b_irw, b_pcw, b_pcsrc,
                   b_asa, b_asb, b_aluop, b_br, b_bc, b_mds, b_ill};

   task automatic check(input string tag, input ctl_t exp, input ctl_t msk);
      ctl_t obs;
      obs = sel ? obs_b : obs_a;
      checks++;
      assert ((obs & msk) === (exp & msk)) else begin
         failures++;
         $error("FAIL %s: observed=%h expected=%h (mask %h)", tag, obs & msk, exp & msk, msk);
      end
   endtask

   // write enables and pulses are checked in every cycle; they must be 0 unless listed
   function automatic ctl_t base_mask();
      ctl_t m;
      m = '0;
      m.regw = 1'b1; m.memw = 1'b1; m.irw = 1'b1; m.pcw = 1'b1;
      m.mds = 1'b1;  m.ill = 1'b1;  m.br = 1'b1;  m.mdsel = 1'b1;
      return m;
   endfunction

   task automatic check_reset(input string tag);
      ctl_t c, m;
      c = '0; c.memr = 1'b1; c.asb = 2'b01;
      m = base_mask();
      m.memr = 1'b1; m.iord = 1'b1; m.asa = 1'b1; m.asb = 2'b11; m.aluop = 3'b111; m.bc = 3'b111;
      check(tag, c, m);
   endtask

   function automatic int classify(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      case (op)
         7'h03:   return C_LOAD;
         7'h23:   return C_STORE;
         7'h33:   return f7 ? (m_ext ? C_MD : C_TRAP) : C_R;
         7'h63:   return (f3 == 3'd2 || f3 == 3'd3) ? C_TRAP : C_BR;
         7'h13:   return C_I;
         7'h67:   return C_JALR;
         7'h6F:   return C_JAL;
         7'h37:   return C_LUI;
         7'h17:   return C_AUIPC;
         default: return C_TRAP;
      endcase
   endfunction

   task automatic add(input string tag, input ctl_t c, input ctl_t xm, input int kind);
      phase_t p;
      p.tag = tag; p.c = c; p.m = base_mask() | xm; p.kind = kind;
      phases.push_back(p);
   endtask

   task automatic build(input logic [6:0] op, input logic [2:0] f3, input logic f7);
      ctl_t c, x;
      int   cls;
      cls = classify(op, f3, f7);
      phases.delete();
      c = '0; x = '0;
      c.memr = 1'b1; c.asb = 2'b01;
      x.memr = 1'b1; x.iord = 1'b1; x.asa = 1'b1; x.asb = 2'b11; x.aluop = 3'b111;
      add("fetch", c, x, 3);
      add("decode", '0, '0, 0);
      if (cls == C_LOAD || cls == C_STORE) begin
         c = '0; x = '0;
         c.asa = 1'b1; c.asb = 2'b10;
         x.asa = 1'b1; x.asb = 2'b11; x.aluop = 3'b111;
         add("memadr", c, x, 0);
      end
      c = '0; x = '0;
      case (cls)
         C_LOAD: begin
            c.iord = 1'b1; x.iord = 1'b1;
            add("memread", c, x, 1);
            c = '0; x = '0;
            c.regw = 1'b1; c.m2r = 2'b01; x.m2r = 2'b11;
            add("memread_comp", c, x, 0);
         end
         C_STORE: begin
            c.iord = 1'b1; c.memw = 1'b1; x.iord = 1'b1;
            add("memwrite", c, x, 1);
         end
         C_R, C_I, C_JALR: begin
            c.asa = 1'b1; c.aluop = 3'b010; c.asb = (cls == C_R) ? 2'b00 : 2'b10;
            x.asa = 1'b1; x.asb = 2'b11; x.aluop = 3'b111;
            add(cls == C_R ? "exec_r" : "exec_i", c, x, 0);
            c = '0; x = '0;
            if (cls == C_JALR) begin
               c.pcw = 1'b1; c.pcsrc = 1'b1; c.m2r = 2'b10; c.regw = 1'b1;
               x.pcsrc = 1'b1; x.m2r = 2'b11;
               add("completion_jalr", c, x, 0);
            end else begin
               c.regw = 1'b1;
               add("completion", c, x, 0);
            end
         end
         C_MD: begin
            add("exec_md", '0, '0, 2);
            c.regw = 1'b1; c.mdsel = 1'b1;
            add("completion_md", c, x, 0);
         end
         C_BR: begin
            c.br = 1'b1; c.pcsrc = 1'b1; c.asa = 1'b1; c.asb = 2'b00; c.aluop = 3'b001; c.bc = f3;
            x.pcsrc = 1'b1; x.asa = 1'b1; x.asb = 2'b11; x.aluop = 3'b111; x.bc = 3'b111;
            add("branch", c, x, 0);
         end
         C_JAL: begin
            c.pcw = 1'b1; c.pcsrc = 1'b1; c.m2r = 2'b10; c.regw = 1'b1;
            x.pcsrc = 1'b1; x.m2r = 2'b11;
            add("exec_j", c, x, 0);
         end
         C_LUI: begin
            c.regw = 1'b1; c.m2r = 2'b11; x.m2r = 2'b11;
            add("exec_lui", c, x, 0);
         end
         C_AUIPC: begin
            add("exec_auipc", '0, '0, 0);
            c.regw = 1'b1;
            add("completion", c, x, 0);
         end
         default: begin
            c.ill = 1'b1;
            add("trap", c, x, 0);
         end
      endcase
   endtask

   // Entered and left at 1 time unit after a rising edge, with the DUT in FETCH.
   task automatic run_instr(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input int abort_at);
      build(op, f3, f7);
      opcode = op; funct3 = f3; funct7_0 = f7;
      $display("instr op=%b f3=%0d f7=%0b dut=%s phases=%0d", op, f3, f7, sel ? "b" : "a",
               phases.size());
      for (int i = 0; i < phases.size(); i++) begin
         bit   done = 1'b0;
         bit   first = 1'b1;
         int   waits = 0;
         bit   rdy;
         ctl_t exp;
         while (!done) begin
            if ((phases[i].kind == 1 || phases[i].kind == 3) && ready_q.size() > 0)
               mem_ready = ready_q.pop_front();
            else
               mem_ready = ($urandom_range(0, 3) != 0);
            if (phases[i].kind == 2 && md_q.size() > 0)
               md_done = md_q.pop_front();
            else
               md_done = ($urandom_range(0, 2) == 0);
            if (waits >= 8) begin
               mem_ready = 1'b1;
               md_done   = 1'b1;
            end
            rdy = wait_en ? mem_ready : 1'b1;
            exp = phases[i].c;
            if (phases[i].kind == 3) begin
               exp.irw = rdy;
               exp.pcw = rdy;
            end
            if (phases[i].kind == 2) exp.mds = first;
            @(negedge clk);
            check(phases[i].tag, exp, phases[i].m);
            if (i == abort_at) begin
               rst = 1'b1;
               #2;
               check_reset("reset_abort");
               @(posedge clk);
               #1;
               rst = 1'b0;
               return;
            end
            done = (phases[i].kind == 0) ||
                   ((phases[i].kind == 1 || phases[i].kind == 3) && rdy) ||
                   (phases[i].kind == 2 && md_done);
            first = 1'b0;
            waits++;
            @(posedge clk);
            #1;
         end
      end
   endtask

   task automatic run_random(input int n);
      logic [6:0] ops [10];
      logic [6:0] op;
      int         idx;
      ops = '{7'h03, 7'h23, 7'h33, 7'h63, 7'h13, 7'h67, 7'h6F, 7'h37, 7'h17, 7'h00};
      for (int k = 0; k < n; k++) begin
         idx = $urandom_range(0, 9);
         op = (idx == 9) ? 7'($urandom) : ops[idx];
         run_instr(op, 3'($urandom), 1'($urandom), -1);
      end
   endtask

   initial begin
      sel = 1'b0; wait_en = 1'b1; m_ext = 1'b1;
      rst = 1'b1; mem_ready = 1'b1; md_done = 1'b0;
      opcode = 7'h00; funct3 = 3'd0; funct7_0 = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check_reset("reset_hold");
      @(posedge clk);
      #1;
      rst = 1'b0;

      // fetch waits 3 cycles, then a zero-wait load
      ready_q = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
      run_instr(7'h03, 3'd2, 1'b0, -1);
      // store with two wait cycles in MEMWRITE
      ready_q = '{1'b1, 1'b0, 1'b0, 1'b1};
      run_instr(7'h23, 3'd2, 1'b0, -1);
      ready_q = '{1'b1};
      run_instr(7'h63, 3'd6, 1'b0, -1);
      ready_q = '{1'b1};
      run_instr(7'h63, 3'd2, 1'b0, -1);
      // mul: md_done arrives on the fifth EXECUTE_MD cycle
      ready_q = '{1'b1};
      md_q = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
      run_instr(7'h33, 3'd0, 1'b1, -1);
      // md_done coincident with md_start
      ready_q = '{1'b1};
      md_q = '{1'b1};
      run_instr(7'h33, 3'd4, 1'b1, -1);
      // reset in EXECUTE_J, then a fetch that must wait for ready after release
      ready_q = '{1'b1};
      run_instr(7'h6F, 3'd0, 1'b0, 2);
      ready_q = '{1'b0, 1'b1};
      run_instr(7'h13, 3'd0, 1'b0, -1);
      run_random(80);

      // second configuration: no wait states, no M extension
      rst = 1'b1;
      sel = 1'b1; wait_en = 1'b0; m_ext = 1'b0;
      mem_ready = 1'b0;
      @(negedge clk);
      check_reset("reset_b");
      @(posedge clk);
      #1;
      rst = 1'b0;
      ready_q = '{1'b0};
      run_instr(7'h33, 3'd0, 1'b1, -1);
      ready_q = '{1'b0, 1'b0};
      run_instr(7'h03, 3'd0, 1'b0, -1);
      run_random(50);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
